// File: rtl/serial_operand_sequencer.sv
// serial_operand_sequencer: register file that streams operands LSB-first to a 1-bit ALU and writes back the result.
// Optional ZERO_REG_EN: register 0 reads as zero and ignores writes.
module serial_operand_sequencer #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op_in,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    input  logic [AW-1:0]    rd_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             alu_rs1,
    output logic             alu_rs2,
    output logic [2:0]       alu_op,
    output logic             alu_en,
    output logic             alu_start,
    input  logic             alu_result
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, wb_val;
    logic [2:0]       op_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt;

    function automatic logic [WIDTH-1:0] rf(input logic [AW-1:0] ad);
        return (ZERO_REG && ad == '0) ? '0 : regs[ad];
    endfunction

    assign rd_data   = rf(rd_sel);
    assign wb_val    = {alu_result, res_sr[WIDTH-1:1]};
    assign alu_rs1   = a_sr[0];
    assign alu_rs2   = b_sr[0];
    assign alu_op    = op_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d   = (state == IDLE && start)       ? SHIFT :
                    (state == SHIFT && cnt == LAST) ? DRAIN :
                    (state == DRAIN)                ? IDLE  : state;
        busy      = state != IDLE;
        alu_en    = state == SHIFT;
        alu_start = state == SHIFT && cnt == '0;
    end

    // Operand shifts replicate the MSB so the serial outputs hold their last bit after SHIFT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            op_q   <= '0;
            rd_q   <= '0;
            cnt    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wr_en && !(ZERO_REG && wr_addr == '0)) regs[wr_addr] <= wr_data;
            if (state == IDLE && start) begin
                a_sr <= rf(rs1_addr);
                b_sr <= rf(rs2_addr);
                op_q <= op_in;
                rd_q <= rd_addr;
                cnt  <= '0;
            end
            if (state == SHIFT) begin
                a_sr <= {a_sr[WIDTH-1], a_sr[WIDTH-1:1]};
                b_sr <= {b_sr[WIDTH-1], b_sr[WIDTH-1:1]};
                cnt  <= cnt + CW'(1);
                if (cnt != '0) res_sr <= wb_val;
            end
            if (state == DRAIN) begin
                res_sr <= wb_val;
                if (!(ZERO_REG && rd_q == '0)) regs[rd_q] <= wb_val;
                done <= 1'b1;
            end
        end
    end
endmodule

// File: doc/serial_operand_sequencer.md
Name: serial_operand_sequencer

Overview:
- Bit-serial operand source and result sink for the 1-bit ALU: a small register file that streams two operands LSB-first onto the ALU's rs1/rs2 inputs and drives alu_op/alu_en/alu_start.
- Reassembles the registered serial alu_result stream and writes it back to a destination register.
- Sits between the control/decode logic (start/op/addresses, host load/readback) and the ALU.

Parameters:
- WIDTH, 8, operand/register width in bits (>=2).
- NREGS, 4, number of registers; address width AW = clog2(NREGS), min 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request one operation; sampled only in IDLE.
- op_in  in  3  ALU op: 000 add, 001 sub, 010 xor, 011 and, 100 or; others yield 0.
- rs1_addr  in  AW  source A register.
- rs2_addr  in  AW  source B register.
- rd_addr  in  AW  destination register.
- wr_en  in  1  host parallel write strobe.
- wr_addr  in  AW  host write address.
- wr_data  in  WIDTH  host write data.
- rd_sel  in  AW  host readback address.
- rd_data  out  WIDTH  combinational read of reg[rd_sel].
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result written.
- alu_rs1  out  1  serial operand A bit to ALU.
- alu_rs2  out  1  serial operand B bit to ALU.
- alu_op  out  3  op to ALU.
- alu_en  out  1  ALU bit-enable.
- alu_start  out  1  high on bit 0 only.
- alu_result  in  1  registered serial result from ALU.

Behaviour:
- Reset: state IDLE; all registers, shift regs, counter cleared to 0; busy=0, done=0, alu_en=0, alu_start=0, alu_rs1=0, alu_rs2=0, alu_op=000. Reset mid-operation aborts it: no writeback, no done.
- FSM: IDLE -> SHIFT -> DRAIN -> IDLE.
- IDLE, edge E0 with start=1: snapshot reg[rs1_addr] and reg[rs2_addr] into shift regs A/B; latch op, rd; cnt=0; go to SHIFT. Snapshot makes rd==rs1/rs2 and later host writes safe.
- SHIFT, edges E1..EW:
  - alu_en=1, alu_rs1=A[0], alu_rs2=B[0], alu_op=latched op, alu_start=(cnt==0).
  - Each edge: A and B shift right, cnt+1.
  - At cnt==WIDTH-1 the next state is DRAIN.
- Result capture: ALU registers bit k at edge E(k+1). The sequencer shifts alu_result into the result register MSB (shift right) at edges E2..E(W+1). After E(W+1), bit k is in position k.
- DRAIN: alu_en=0, alu_start=0. At edge E(W+1):
  - capture the final bit;
  - write the result to reg[rd];
  - done<=1 for exactly one cycle;
  - return to IDLE.
- busy=1 from after E0 through the cycle before done. Latency from start to done visible is WIDTH+1 edges; back-to-back start is accepted in the done cycle.
- alu_en is low for at least one cycle between operations, guaranteeing the ALU carry register returns to 0 before an add.
- start while busy is ignored (not queued).
- Host write vs writeback, same edge, same address: writeback wins. Different addresses: both take effect.
- Host write to a source register during an operation does not affect that operation.
- Arithmetic is modulo 2^WIDTH; carry/borrow out is discarded.
- alu_rs1/alu_rs2 hold their last value outside SHIFT and are don't-care when alu_en=0.

Optional Feature:
- Macro ZERO_REG_EN.
- Defined: register 0 is hardwired to 0. Reads, snapshots and rd_data return 0; host writes and writebacks to address 0 are discarded, but done still pulses.
- Undefined: register 0 is an ordinary register.

Test Plan (WIDTH=8, NREGS=4, real ALU attached):
- r1=0x5A, r2=0x33, add rd=3 -> done exactly 9 cycles after start edge; r3=0x8D; alu_start high only on first alu_en cycle.
- r1=0x10, r2=0x01 sub -> 0x0F; r1=0x00, r2=0x01 sub -> 0xFF; r1=0xFF, r2=0x01 add -> 0x00 (wrap).
- Back-to-back sub (0x05-0x03=0x02) then add (0x01+0x01=0x02), second start in done cycle -> no carry leakage; alu_en low one cycle between ops.
- rd=rs1=1, r1=0x0F, r2=0xF0, or -> r1=0xFF; xor 0xAA^0xFF -> 0x55; and 0xAA&0x0F -> 0x0A; op 111 -> 0x00.
- start pulses and host write to r2 during busy -> ignored and no effect on result; host write to rd on writeback edge -> writeback value kept.
- rst_n low mid-SHIFT -> next cycle busy=0, all regs 0, no done. With ZERO_REG_EN: write 0x77 to r0 -> rd_data(0)=0x00.
